nco_modulator: RTL and testbench
================================

NCO_MODULATOR -- requirements
Module: nco_modulator

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed output sample width.
REQ-002 SHALL have parameter PHASE_W, default 16, phase accumulator width.
REQ-003 SHALL have parameter LUT_AW, default 8, sine LUT address width (full wave, 2^LUT_AW entries).
REQ-004 SHALL have parameter SYM_LEN, default 64, clock cycles per symbol.
REQ-005 SHALL have parameters FTW0..FTW3, defaults 1024, 2048, 4096, 8192, carrier tuning words selected by freq_sel.
REQ-006 SHALL have port clk, input, 1, the single clock (all logic rising-edge).
REQ-007 SHALL have port rst_n, input, 1, reset (asynchronous, active-low).
REQ-008 SHALL have port enable, input, 1, run request.
REQ-009 SHALL have port mode, input, 2, 00 FSK, 01 ASK, 10 BPSK, 11 QPSK.
REQ-010 SHALL have port freq_sel, input, 2, carrier select.
REQ-011 SHALL have port s_valid, input, 1, data bit valid.
REQ-012 SHALL have port s_data, input, 1, data bit.
REQ-013 SHALL have port s_ready, output, 1, block accepts a bit.
REQ-014 SHALL have port out_sample, output, DATA_W, signed modulated sample.
REQ-015 SHALL have port out_valid, output, 1, out_sample valid.
REQ-016 SHALL have port sym_strobe, output, 1, one-cycle pulse at each symbol boundary.
REQ-017 SHALL have port underrun, output, 1, one-cycle pulse when a boundary finds no complete next symbol.

Function
REQ-018 SHALL use states IDLE, FILL, RUN; IDLE->FILL when enable=1; FILL->RUN when next-symbol buffer complete; RUN->IDLE at a symbol boundary when enable=0 (symbol in progress always finishes).
REQ-019 SHALL accept a bit on any cycle with s_valid=1 and s_ready=1; s_ready=1 in FILL/RUN while the next-symbol buffer is incomplete, 0 in IDLE.
REQ-020 SHALL capture mode and freq_sel into the next-symbol buffer on acceptance of its first bit; these take effect only when the buffer becomes current.
REQ-021 SHALL require 2 bits per symbol in QPSK (first accepted = MSB), 1 bit otherwise.
REQ-022 SHALL run a symbol counter 0..SYM_LEN-1 in RUN; boundary = counter wrap, or the FILL->RUN transition; at a boundary the next buffer moves to current and sym_strobe pulses.
REQ-023 SHALL, at a boundary with incomplete next buffer, pulse underrun with sym_strobe, make the new symbol silent (sample 0) for SYM_LEN cycles, and keep any partial bits.
REQ-024 SHALL clear the phase accumulator on FILL->RUN; add the symbol's tuning word every RUN cycle, wrapping mod 2^PHASE_W; never reset at symbol boundaries (phase-continuous).
REQ-025 SHALL use tuning word FTW[freq_sel], except FSK bit 1 uses FTW[freq_sel] shifted left 1 (truncated to PHASE_W).
REQ-026 SHALL add a phase offset of 2^PHASE_W times: BPSK bit1 0, bit0 1/2; QPSK 00 1/8, 01 3/8, 11 5/8, 10 7/8; FSK/ASK 0.
REQ-027 SHALL address the LUT with the top LUT_AW bits of (acc+offset); entry k = round((2^(DATA_W-1)-1)*sin(2*pi*k/2^LUT_AW)).
REQ-028 SHALL output LUT value, except ASK bit 0 and silent symbols output 0.
REQ-029 SHALL register out_sample 2 cycles after the accumulator value it is derived from; out_valid follows the same 2-cycle delay of RUN.
REQ-030 SHALL drive out_sample 0 whenever out_valid=0.

Reset
REQ-031 SHALL, on rst_n=0, immediately force state IDLE, accumulator, counter, buffers, pipeline 0, and all outputs 0, regardless of operation in progress.
REQ-032 SHALL resume only via IDLE->FILL after rst_n returns high.

Verification (defaults)
REQ-033 BPSK, freq_sel 0, bits 1,0 -> symbol 1 cycle offset 16 sample +32767; symbol 2 cycle offset 16 sample -32767; sym_strobe at both boundaries.
REQ-034 ASK, bits 0,1 -> 64 samples of 0, then offset-16 sample +32767.
REQ-035 QPSK, bits 1,1 -> first sample of symbol (LUT index 160) = -23170.
REQ-036 FSK, freq_sel 0, bits 0,1 -> increments 1024 then 2048; accumulator 0 at end of symbol 2, no phase jump at boundary.
REQ-037 BPSK one symbol then s_valid held 0 -> underrun and sym_strobe at cycle 64, next 64 samples 0, out_valid stays 1.
REQ-038 rst_n low mid-RUN -> out_sample 0, out_valid 0, s_ready 0 same cycle; enable kept 1 after release -> FILL, s_ready 1.

Source files
------------

// File: rtl/nco_if.sv
// nco_if: control, bit-stream handshake and sample output bundle for nco_modulator.
//   enable     run request
//   mode       00 FSK, 01 ASK, 10 BPSK, 11 QPSK
//   freq_sel   carrier select
//   s_valid / s_data / s_ready   one data bit per accepted handshake
//   out_sample / out_valid       signed modulated sample stream
//   sym_strobe / underrun        symbol-boundary pulses
// slave = modulator side, master = driver side.
interface nco_if #(
  parameter int unsigned DATA_W = 16
);
  logic                     enable;
  logic [1:0]               mode;
  logic [1:0]               freq_sel;
  logic                     s_valid;
  logic                     s_data;
  logic                     s_ready;
  logic signed [DATA_W-1:0] out_sample;
  logic                     out_valid;
  logic                     sym_strobe;
  logic                     underrun;

  modport slave (
    input  enable, mode, freq_sel, s_valid, s_data,
    output s_ready, out_sample, out_valid, sym_strobe, underrun
  );

  modport master (
    output enable, mode, freq_sel, s_valid, s_data,
    input  s_ready, out_sample, out_valid, sym_strobe, underrun
  );
endinterface

// File: rtl/nco_modulator.sv
// nco_modulator: phase-continuous NCO driving FSK / ASK / BPSK / QPSK symbols.
// Bits are collected into a next-symbol buffer; at each symbol boundary the
// buffer becomes the current symbol, which selects the tuning word, phase
// offset and amplitude gating for SYM_LEN cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    nco_if slave modport (control, bit handshake, sample output)
module nco_modulator #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned LUT_AW  = 8,
  parameter int unsigned SYM_LEN = 64,
  parameter int unsigned FTW0    = 1024,
  parameter int unsigned FTW1    = 2048,
  parameter int unsigned FTW2    = 4096,
  parameter int unsigned FTW3    = 8192
) (
  input  logic  clk,
  input  logic  rst_n,
  nco_if.slave  bus
);

  localparam int unsigned LUT_N = 1 << LUT_AW;
  localparam int unsigned CNT_W = (SYM_LEN > 1) ? $clog2(SYM_LEN) : 1;
  localparam real         PI    = 3.14159265358979323846;

  localparam logic [1:0] M_FSK  = 2'd0;
  localparam logic [1:0] M_ASK  = 2'd1;
  localparam logic [1:0] M_BPSK = 2'd2;
  localparam logic [1:0] M_QPSK = 2'd3;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] fsel;
    logic [1:0] bits;   // QPSK: [1] = first accepted bit; others use [0]
  } sym_t;

  state_t                   state_q, state_d;
  sym_t                     nxt_q, cur_q;
  logic [1:0]               nxt_cnt_q;
  logic                     nxt_full_q;
  logic                     cur_silent_q;
  logic [PHASE_W-1:0]       acc_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     strobe_q, underrun_q;
  logic [LUT_AW-1:0]        p1_addr_q;
  logic                     p1_zero_q, p1_valid_q;
  logic signed [DATA_W-1:0] out_sample_q;
  logic                     out_valid_q;

  logic                     s_ready_c, accept_c, boundary_c, start_c, wrap_c;
  logic [1:0]               mode_eff_c, need_c, nxt_cnt_inc_c;
  logic [PHASE_W-1:0]       ftw_base_c, ftw_c, off_c, phase_c;
  logic [2:0]               oct_c;
  logic                     zero_c;

  // Quarter-wave symmetry is not exploited: a full-wave table keeps addressing trivial.
  function automatic logic signed [DATA_W-1:0] sine_entry(input int k);
    real amp, v;
    amp = (2.0 ** (DATA_W - 1)) - 1.0;
    v   = amp * $sin(2.0 * PI * real'(k) / real'(LUT_N));
    v   = (v >= 0.0) ? $floor(v + 0.5) : -$floor(-v + 0.5);
    return DATA_W'($rtoi(v));
  endfunction

  logic signed [DATA_W-1:0] lut [LUT_N];

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    assign lut[k] = sine_entry(k);
  end

  assign s_ready_c  = (state_q != IDLE) && !nxt_full_q;
  assign accept_c   = bus.s_valid && s_ready_c;
  assign wrap_c     = (state_q == RUN) && (cnt_q == CNT_W'(SYM_LEN - 1));
  assign start_c    = (state_q == FILL) && nxt_full_q;

  // Mode of the symbol being collected: live input on its first bit, captured after.
  assign mode_eff_c    = (nxt_cnt_q == 2'd0) ? bus.mode : nxt_q.mode;
  assign need_c        = (mode_eff_c == M_QPSK) ? 2'd2 : 2'd1;
  assign nxt_cnt_inc_c = nxt_cnt_q + 2'd1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and symbol-boundary decode; a running symbol always completes.
  always_comb begin
    state_d    = state_q;
    boundary_c = 1'b0;
    case (state_q)
      IDLE: if (bus.enable) state_d = FILL;
      FILL: if (nxt_full_q) begin
        state_d    = RUN;
        boundary_c = 1'b1;
      end
      RUN: if (wrap_c) begin
        if (!bus.enable) state_d = IDLE;
        else             boundary_c = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next-symbol buffer and current symbol; an underrun keeps partial bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nxt_q        <= '0;
      nxt_cnt_q    <= '0;
      nxt_full_q   <= 1'b0;
      cur_q        <= '0;
      cur_silent_q <= 1'b0;
    end else if (boundary_c && nxt_full_q) begin
      cur_q        <= nxt_q;
      cur_silent_q <= 1'b0;
      nxt_cnt_q    <= '0;
      nxt_full_q   <= 1'b0;
    end else begin
      if (boundary_c) cur_silent_q <= 1'b1;
      if (accept_c) begin
        if (nxt_cnt_q == 2'd0) begin
          nxt_q.mode <= bus.mode;
          nxt_q.fsel <= bus.freq_sel;
          nxt_q.bits <= {1'b0, bus.s_data};
        end else begin
          nxt_q.bits <= {nxt_q.bits[0], bus.s_data};
        end
        nxt_cnt_q <= nxt_cnt_inc_c;
        if (nxt_cnt_inc_c == need_c) nxt_full_q <= 1'b1;
      end
    end
  end

  // Tuning word, phase offset (in eighths of a turn) and gating of the current symbol.
  // A silent symbol keeps the previous tuning word so the phase keeps advancing.
  always_comb begin
    ftw_base_c = PHASE_W'(FTW0);
    case (cur_q.fsel)
      2'd0:    ftw_base_c = PHASE_W'(FTW0);
      2'd1:    ftw_base_c = PHASE_W'(FTW1);
      2'd2:    ftw_base_c = PHASE_W'(FTW2);
      default: ftw_base_c = PHASE_W'(FTW3);
    endcase
    ftw_c = ftw_base_c;
    if (cur_q.mode == M_FSK && cur_q.bits[0]) ftw_c = ftw_base_c << 1;

    oct_c = 3'd0;
    case (cur_q.mode)
      M_BPSK: oct_c = cur_q.bits[0] ? 3'd0 : 3'd4;
      M_QPSK: begin
        case (cur_q.bits)
          2'b00:   oct_c = 3'd1;
          2'b01:   oct_c = 3'd3;
          2'b11:   oct_c = 3'd5;
          default: oct_c = 3'd7;
        endcase
      end
      default: oct_c = 3'd0;
    endcase

    zero_c = cur_silent_q || (cur_q.mode == M_ASK && !cur_q.bits[0]);
  end

  assign off_c   = {oct_c, {(PHASE_W - 3){1'b0}}};
  assign phase_c = acc_q + off_c;

  // Phase accumulator and symbol counter; phase is continuous across boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (start_c) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      acc_q <= acc_q + ftw_c;
      cnt_q <= wrap_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Boundary pulses, aligned with the first cycle of the new symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      strobe_q   <= boundary_c;
      underrun_q <= boundary_c && !nxt_full_q;
    end
  end

  // Two-stage sample pipeline: LUT address, then LUT read / gating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_addr_q    <= '0;
      p1_zero_q    <= 1'b0;
      p1_valid_q   <= 1'b0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      p1_addr_q    <= LUT_AW'(phase_c >> (PHASE_W - LUT_AW));
      p1_zero_q    <= zero_c;
      p1_valid_q   <= (state_q == RUN);
      out_valid_q  <= p1_valid_q;
      out_sample_q <= (p1_valid_q && !p1_zero_q) ? lut[p1_addr_q] : '0;
    end
  end

  assign bus.s_ready    = s_ready_c;
  assign bus.out_sample = out_sample_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sym_strobe = strobe_q;
  assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_nco_modulator.sv
// tb_nco_modulator: self-checking bench for nco_modulator (default parameters).
// A symbol-level reference model turns every accepted symbol into its 64
// expected samples; each valid output sample is compared in order.
module tb_nco_modulator;

  localparam int DW = 16;
  localparam int SL = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nco_if #(.DATA_W(DW)) bus ();

  nco_modulator #(.DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int smp;
    bit first;
    bit und;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  int   obs_q[$];
  int   phase = 0;
  int   last_ftw = 0;
  int   mon_cnt = 0, mon_mode = 0, mon_fsel = 0, mon_bits = 0;
  int   strobes = 0, unders = 0, vfalls = 0;
  bit   s1 = 0, s2 = 0, u1 = 0, u2 = 0, pv = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int ftw_tab(input int f);
    case (f)
      0: return 1024;
      1: return 2048;
      2: return 4096;
      default: return 8192;
    endcase
  endfunction

  function automatic int sine_ref(input int idx);
    real v;
    v = 32767.0 * $sin(2.0 * 3.141592653589793 * idx / 256.0);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
  endfunction

  function automatic logic signed [31:0] obs_at(input int i);
    if (i < obs_q.size()) return obs_q[i];
    return 'x;
  endfunction

  // Expected samples of one symbol; the phase runs on across symbols.
  task automatic push_symbol(input int m, input int b, input int f, input bit silent, input bit und);
    int ftw, off, p;
    bit zero;
    exp_t e;
    if (silent) ftw = last_ftw;
    else begin
      ftw = ftw_tab(f);
      if (m == 0 && (b & 1) == 1) ftw = (ftw << 1) & 65535;
    end
    off = 0;
    if (m == 2) off = ((b & 1) == 1) ? 0 : 32768;
    if (m == 3) case (b)
      0: off = 8192;
      1: off = 24576;
      3: off = 40960;
      default: off = 57344;
    endcase
    zero = silent || (m == 1 && (b & 1) == 0);
    for (int n = 0; n < SL; n++) begin
      p = (phase + n * ftw + off) & 65535;
      e.smp = zero ? 0 : sine_ref(p >> 8);
      e.first = (n == 0);
      e.und = (n == 0) && und;
      exp_q.push_back(e);
    end
    phase = (phase + SL * ftw) & 65535;
    last_ftw = ftw;
  endtask

  task automatic flush_model();
    exp_q.delete();
    obs_q.delete();
    phase = 0;
    last_ftw = 0;
    mon_cnt = 0;
    strobes = 0;
    unders = 0;
    vfalls = 0;
  endtask

  // Output checker and input monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      s1 = 0; s2 = 0; u1 = 0; u2 = 0; pv = 0;
    end else begin
      if (bus.out_valid === 1'b1) begin
        obs_q.push_back(int'(bus.out_sample));
        if (exp_q.size() == 0) chk("unexpected_sample", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sample", bus.out_sample, e.smp);
          chk("strobe_align", 32'(s2), 32'(e.first));
          chk("underrun_align", 32'(u2), 32'(e.und));
        end
      end else begin
        chk("idle_zero", bus.out_sample, 0);
      end
      if (pv && bus.out_valid !== 1'b1) vfalls++;
      pv = (bus.out_valid === 1'b1);
      s2 = s1; s1 = (bus.sym_strobe === 1'b1);
      u2 = u1; u1 = (bus.underrun === 1'b1);
      if (s1) strobes++;
      if (u1) unders++;
      if (bus.s_valid && bus.s_ready === 1'b1) begin
        if (mon_cnt == 0) begin
          mon_mode = int'(bus.mode);
          mon_fsel = int'(bus.freq_sel);
          mon_bits = 0;
        end
        mon_bits = ((mon_bits << 1) | int'(bus.s_data)) & 3;
        mon_cnt++;
        if (mon_cnt == ((mon_mode == 3) ? 2 : 1)) begin
          push_symbol(mon_mode, mon_bits, mon_fsel, 1'b0, 1'b0);
          mon_cnt = 0;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.s_valid = 1'b0; bus.s_data = 1'b0;
    bus.mode = 2'd0; bus.freq_sel = 2'd0;
    flush_model();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send_bit(input int m, input int f, input int b);
    bit ok = 0;
    bus.mode = 2'(m); bus.freq_sel = 2'(f); bus.s_data = 1'(b); bus.s_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) begin ok = 1; break; end
    end
    @(posedge clk); #1 bus.s_valid = 1'b0;
    if (!ok) chk("timeout_send", 0, 1);
  endtask

  task automatic wait_drain();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_start", 0, 1);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b1) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_drain", 0, 1);
    chk("model_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Let the last buffered symbol become current, then stop at its end.
  task automatic finish_run();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.s_ready === 1'b1) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_finish", 0, 1);
    @(posedge clk); #1 bus.enable = 1'b0;
    wait_drain();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_s_ready", 32'(bus.s_ready), 0);
    chk("rst_strobe", 32'(bus.sym_strobe), 0);
    chk("rst_underrun", 32'(bus.underrun), 0);

    // BPSK 1,0 on carrier 0
    do_reset();
    @(posedge clk); #1 bus.enable = 1'b1;
    send_bit(2, 0, 1);
    send_bit(2, 0, 0);
    finish_run();
    chk("bpsk_sym1_off16", obs_at(16), 32767);
    chk("bpsk_sym2_off16", obs_at(SL + 16), -32767);
    chk("bpsk_strobes", strobes, 2);
    chk("bpsk_len", obs_q.size(), 2 * SL);

    // ASK 0,1
    do_reset();
    @(posedge clk); #1 bus.enable = 1'b1;
    send_bit(1, 0, 0);
    send_bit(1, 0, 1);
    finish_run();
    chk("ask_off_first", obs_at(0), 0);
    chk("ask_off_last", obs_at(SL - 1), 0);
    chk("ask_on_off16", obs_at(SL + 16), 32767);

    // QPSK 11
    do_reset();
    @(posedge clk); #1 bus.enable = 1'b1;
    send_bit(3, 0, 1);
    send_bit(3, 0, 1);
    finish_run();
    chk("qpsk11_first", obs_at(0), -23170);
    chk("qpsk_len", obs_q.size(), SL);

    // FSK 0,1,0: phase continuous, accumulator back at 0 after each symbol
    do_reset();
    @(posedge clk); #1 bus.enable = 1'b1;
    send_bit(0, 0, 0);
    send_bit(0, 0, 1);
    send_bit(0, 0, 0);
    finish_run();
    chk("fsk0_off8", obs_at(8), 23170);
    chk("fsk0_last", obs_at(SL - 1), -3212);
    chk("fsk1_first", obs_at(SL), 0);
    chk("fsk1_off8", obs_at(SL + 8), 32767);
    chk("fsk_sym3_first", obs_at(2 * SL), 0);
    chk("fsk_sym3_off16", obs_at(2 * SL + 16), 32767);

    // Underrun: one BPSK symbol, then no data
    do_reset();
    @(posedge clk); #1 bus.enable = 1'b1;
    send_bit(2, 0, 1);
    push_symbol(0, 0, 0, 1'b1, 1'b1);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (unders != 0) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_underrun", 0, 1);
    @(posedge clk); #1 bus.enable = 1'b0;
    wait_drain();
    chk("ur_count", unders, 1);
    chk("ur_strobes", strobes, 2);
    chk("ur_silent_first", obs_at(SL), 0);
    chk("ur_silent_last", obs_at(2 * SL - 1), 0);
    chk("ur_valid_gaps", vfalls, 1);
    chk("ur_len", obs_q.size(), 2 * SL);

    // Randomized stream: random modes, carriers, bits and valid gaps
    do_reset();
    @(posedge clk); #1 bus.enable = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      bus.s_valid  = ($urandom_range(0, 3) != 0);
      bus.s_data   = 1'($urandom);
      bus.mode     = 2'($urandom);
      bus.freq_sel = 2'($urandom);
      @(posedge clk); #1;
    end
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.s_ready !== 1'b1) begin ok = 1; break; end
    end
    if (!ok) chk("timeout_rand_full", 0, 1);
    @(posedge clk); #1 bus.s_valid = 1'b0;
    finish_run();
    chk("rand_underruns", unders, 0);

    // Reset in the middle of a run
    do_reset();
    @(posedge clk); #1 bus.enable = 1'b1;
    send_bit(2, 1, 1);
    send_bit(2, 1, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("pre_rst_valid", 32'(bus.out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_sample", bus.out_sample, 0);
    chk("midrst_valid", 32'(bus.out_valid), 0);
    chk("midrst_ready", 32'(bus.s_ready), 0);
    flush_model();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", 32'(bus.s_ready), 1);
    chk("post_rst_valid", 32'(bus.out_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
